alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter MULDIV_WAIT, default 4: extra settle cycles granted to mul/div before capture; legal range 0..15.
REQ-002 clock  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 req_valid  in  1  requester presents an operation.
REQ-005 req_ready  out  1  sequencer can accept; high only in IDLE.
REQ-006 req_op  in  5  operation code: add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, mul 01111, div 10000, neg 10001, not 10010.
REQ-007 req_a  in  32  first operand (Y side); req_b  in  32  second operand (B side).
REQ-008 alu_y  out  32; alu_b  out  32; alu_op  out  5  drive the shared ALU.
REQ-009 alu_c  in  64  ALU result.
REQ-010 res_valid  out  1; res_ready  in  1  result handshake.
REQ-011 res_lo  out  32, res_hi  out  32  captured result (Z register low/high).
REQ-012 res_illegal  out  1, res_divz  out  1  status flags qualified by res_valid.
REQ-013 busy  out  1  high in any state other than IDLE; op_count  out  16  completed-result counter.

Function
REQ-014 States: IDLE, EXEC, DONE; encoding is implementation choice.
REQ-015 Accept occurs on an edge where req_valid=1 and req_ready=1; at that edge req_op/req_a/req_b are latched into op_r/a_r/b_r.
REQ-016 alu_y=a_r and alu_b=b_r at all times; alu_op=op_r in EXEC, 00000 in IDLE and DONE.
REQ-017 Legal, non-fault op: accept edge goes IDLE->EXEC and loads wait counter with 0 (single-cycle ops) or MULDIV_WAIT (mul, div).
REQ-018 EXEC, counter nonzero: decrement, stay in EXEC; counter zero: capture alu_c[31:0]->res_lo, alu_c[63:32]->res_hi, go DONE.
REQ-019 Latency: single-cycle op accepted at edge k -> res_valid high after edge k+1; mul/div -> after edge k+1+MULDIV_WAIT.
REQ-020 Opcode outside the REQ-006 table: accept edge goes IDLE->DONE directly, res_lo=res_hi=0, res_illegal=1; ALU never sees the op.
REQ-021 div with req_b=0: accept edge goes IDLE->DONE directly, res_lo=res_hi=0, res_divz=1.
REQ-022 res_illegal and res_divz are cleared at every accept except as set by REQ-020/021.
REQ-023 DONE: res_valid=1; res_lo/res_hi/flags held stable until the edge with res_ready=1, which returns to IDLE and increments op_count.
REQ-024 op_count wraps 0xFFFF->0x0000; increments once per completed result handshake, never on accept or reset.
REQ-025 req_ready=0 in EXEC and DONE; req_valid in those states is ignored and the held operands are unchanged.
REQ-026 No accept in the same edge as a DONE->IDLE handshake; next accept earliest one edge later.
REQ-027 res_ready while not in DONE has no effect.

Reset
REQ-028 reset=1 at an edge forces IDLE regardless of state, abandoning any operation with no result produced.
REQ-029 Reset values: res_valid=0, busy=0, req_ready=1 (after reset deasserts), res_lo=res_hi=0, res_illegal=res_divz=0, op_count=0, op_r=00000, a_r=b_r=0, wait counter=0.
REQ-030 reset has priority over accept, counting and result handshake on the same edge.

Verification
REQ-031 add a=5,b=7 accepted at edge k -> res_valid after k+1, res_lo=12, res_hi=0, flags 0; res_ready=1 -> op_count=1.
REQ-032 mul a=0x00010000,b=0x00010000, MULDIV_WAIT=4, accept at k -> res_valid after k+5, res_hi=1, res_lo=0, busy high k+1..k+5.
REQ-033 div a=9,b=0 -> res_valid after accept edge, res_divz=1, res_lo=res_hi=0, alu_op stays 00000 throughout.
REQ-034 op 00000 -> res_illegal=1, results 0; next accept of sub a=3,b=1 -> res_lo=2, res_illegal=0.
REQ-035 res_ready held low 3 cycles in DONE with req_valid=1 -> res_* stable, req_ready=0, op_count unchanged; release -> IDLE, op_count+1.
REQ-036 reset asserted during mul wait (counter=2) -> next cycle state IDLE, res_valid=0, res_lo=res_hi=0, op_count unchanged, no res_valid ever for that op.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Request/result handshake bundle between a requester and alu_op_sequencer.
// The requester drives the master side; the sequencer sits on the slave side.
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic        res_illegal;
    logic        res_divz;

    modport master (
        output req_valid, req_op, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_lo, res_hi, res_illegal, res_divz
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, res_ready,
        output req_ready, res_valid, res_lo, res_hi, res_illegal, res_divz
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one operation at a time through a shared external ALU: latch operands,
// let the ALU settle (longer for mul/div), capture the 64-bit result and hold it until taken.
module alu_op_sequencer #(
    parameter int unsigned MULDIV_WAIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    alu_op_sequencer_if.slave   bus,
    output logic [31:0]         alu_y,
    output logic [31:0]         alu_b,
    output logic [4:0]          alu_op,
    input  logic [63:0]         alu_c,
    output logic                busy,
    output logic [15:0]         op_count
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Only the low four bits are meaningful; the legal range is 0..15.
    localparam logic [3:0] WAIT_LOAD = 4'(MULDIV_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [4:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic op_is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    state_t      state_reg;
    logic [4:0]  op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [3:0]  wait_reg;
    logic [31:0] res_lo_reg;
    logic [31:0] res_hi_reg;
    logic        illegal_reg;
    logic        divz_reg;
    logic        res_valid_reg;
    logic        req_ready_reg;
    logic        busy_reg;
    logic [4:0]  alu_op_reg;
    logic [15:0] op_count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            op_reg        <= 5'b00000;
            a_reg         <= 32'h0;
            b_reg         <= 32'h0;
            wait_reg      <= 4'h0;
            res_lo_reg    <= 32'h0;
            res_hi_reg    <= 32'h0;
            illegal_reg   <= 1'b0;
            divz_reg      <= 1'b0;
            res_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            alu_op_reg    <= 5'b00000;
            op_count_reg  <= 16'h0000;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_reg        <= bus.req_op;
                        a_reg         <= bus.req_a;
                        b_reg         <= bus.req_b;
                        illegal_reg   <= 1'b0;
                        divz_reg      <= 1'b0;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        // Faulting ops never reach the ALU: report immediately with a zero result.
                        if (!op_is_legal(bus.req_op)) begin
                            state_reg     <= ST_DONE;
                            res_lo_reg    <= 32'h0;
                            res_hi_reg    <= 32'h0;
                            illegal_reg   <= 1'b1;
                            res_valid_reg <= 1'b1;
                        end else if ((bus.req_op == OP_DIV) && (bus.req_b == 32'h0)) begin
                            state_reg     <= ST_DONE;
                            res_lo_reg    <= 32'h0;
                            res_hi_reg    <= 32'h0;
                            divz_reg      <= 1'b1;
                            res_valid_reg <= 1'b1;
                        end else begin
                            state_reg  <= ST_EXEC;
                            wait_reg   <= op_is_muldiv(bus.req_op) ? WAIT_LOAD : 4'h0;
                            alu_op_reg <= bus.req_op;
                        end
                    end
                end
                ST_EXEC: begin
                    if (wait_reg != 4'h0) begin
                        wait_reg <= wait_reg - 4'h1;
                    end else begin
                        state_reg     <= ST_DONE;
                        res_lo_reg    <= alu_c[31:0];
                        res_hi_reg    <= alu_c[63:32];
                        res_valid_reg <= 1'b1;
                        alu_op_reg    <= 5'b00000;
                    end
                end
                ST_DONE: begin
                    // req_ready only rises here, so an accept cannot share this edge.
                    if (bus.res_ready) begin
                        state_reg     <= ST_IDLE;
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        req_ready_reg <= 1'b1;
                        op_count_reg  <= op_count_reg + 16'h0001;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    res_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    req_ready_reg <= 1'b1;
                    alu_op_reg    <= 5'b00000;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_reg;
    assign bus.res_valid   = res_valid_reg;
    assign bus.res_lo      = res_lo_reg;
    assign bus.res_hi      = res_hi_reg;
    assign bus.res_illegal = illegal_reg;
    assign bus.res_divz    = divz_reg;
    assign alu_y           = a_reg;
    assign alu_b           = b_reg;
    assign alu_op          = alu_op_reg;
    assign busy            = busy_reg;
    assign op_count        = op_count_reg;

endmodule
